// File: rtl/conv_out_pkg.sv
// Shared constants for the conv output FIFO bank.
// Row geometry derives from the quantised pixel width and PE parallelism.
package conv_out_pkg;

    localparam int SA_ROW_NUM    = 3;
    localparam int SA_COLUMN_NUM = 4;
    localparam int SA_NUM        = SA_ROW_NUM * SA_COLUMN_NUM;

    localparam int QUANT_WIDTH   = 8;
    localparam int PE_ROWS       = 2;
    localparam int PE_COLS       = 2;
    localparam int PE_LANES      = 16;
    localparam int ROW_WIDTH     = QUANT_WIDTH * PE_ROWS * PE_COLS * PE_LANES;

    localparam int DEPTH_LOG2    = 5;
    localparam int FIFO_DEPTH    = 1 << DEPTH_LOG2;
    localparam int CNT_WIDTH     = DEPTH_LOG2 + 1;
    localparam int AFULL_LEVEL   = FIFO_DEPTH - 2;

    localparam int BEAT_WIDTH    = 16;
    localparam int SEL_WIDTH     = $clog2(SA_NUM);

    // True when more than one bit of v is set.
    function automatic logic multi_hot(input logic [SA_NUM-1:0] v);
        return |(v & (v - 1'b1));
    endfunction

endpackage

// File: rtl/conv_out_row_fifo.sv
// Single synchronous row FIFO; dout is registered on a successful pop.
// Ports: clk, reset, push/din, pop/dout, count, full, empty, ovf, udf.
import conv_out_pkg::*;

module conv_out_row_fifo (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [ROW_WIDTH-1:0] din,
    output logic [ROW_WIDTH-1:0] dout,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 full,
    output logic                 empty,
    output logic                 ovf,
    output logic                 udf
);

    logic [ROW_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [ROW_WIDTH-1:0]  dout_q, dout_d;
    logic                  wr_ok, rd_ok;

    assign full  = (count_q == CNT_WIDTH'(FIFO_DEPTH));
    assign empty = (count_q == '0);

    // Acceptance uses the pre-edge state: a full FIFO drops the push even
    // when popped in the same cycle, and an empty one never bypasses.
    assign wr_ok = push & ~full;
    assign rd_ok = pop & ~empty;
    assign ovf   = push & full;
    assign udf   = pop & empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        count_d  = count_q + CNT_WIDTH'(wr_ok) - CNT_WIDTH'(rd_ok);
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            dout_d   = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = dout_q;
    assign count = count_q;

endmodule

// File: rtl/conv_out_fifo_bank.sv
// Bank of per-SA row FIFOs with one-hot read mux, tile beat counter and
// sticky error flags. Ports: write side (wr_en/wr_data), read side
// (fifo_rds -> fifo_data/valid), status (full/empty/almost_full), tile
// control (tile_start/tile_beats -> quantify_add_end), error flags.
import conv_out_pkg::*;

module conv_out_fifo_bank (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tile_start,
    input  logic [BEAT_WIDTH-1:0]       tile_beats,
    input  logic [SA_NUM-1:0]           wr_en,
    input  logic [SA_NUM*ROW_WIDTH-1:0] wr_data,
    input  logic [SA_NUM-1:0]           fifo_rds,
    output logic [ROW_WIDTH-1:0]        fifo_data,
    output logic                        fifo_data_valid,
    output logic [SA_NUM-1:0]           full,
    output logic [SA_NUM-1:0]           empty,
    output logic                        almost_full,
    output logic                        quantify_add_end,
    output logic                        overflow_err,
    output logic                        underflow_err,
    output logic                        multi_rd_err
);

    logic [ROW_WIDTH-1:0]  dout_a [SA_NUM];
    logic [CNT_WIDTH-1:0]  cnt_a  [SA_NUM];
    logic [SA_NUM-1:0]     pop_v, rd_ok_v, ovf_v, udf_v;
    logic                  multi_rd, beat;

    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  valid_q, valid_d;
    logic [BEAT_WIDTH-1:0] tile_beats_q, tile_beats_d;
    logic [BEAT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                  add_end_q, add_end_d;
    logic                  ovf_err_q, ovf_err_d;
    logic                  udf_err_q, udf_err_d;
    logic                  multi_err_q, multi_err_d;

    // A multi-hot read is rejected outright: no FIFO pops.
    assign multi_rd = multi_hot(fifo_rds);
    assign pop_v    = multi_rd ? '0 : fifo_rds;
    assign rd_ok_v  = pop_v & ~empty;
    assign beat     = |(wr_en & ~full);

    genvar g;
    generate
        for (g = 0; g < SA_NUM; g++) begin : g_fifo
            conv_out_row_fifo u_fifo (
                .clk   (clk),
                .reset (reset),
                .push  (wr_en[g]),
                .pop   (pop_v[g]),
                .din   (wr_data[g*ROW_WIDTH +: ROW_WIDTH]),
                .dout  (dout_a[g]),
                .count (cnt_a[g]),
                .full  (full[g]),
                .empty (empty[g]),
                .ovf   (ovf_v[g]),
                .udf   (udf_v[g])
            );
        end
    endgenerate

    always_comb begin
        almost_full = 1'b0;
        for (int i = 0; i < SA_NUM; i++) begin
            if (cnt_a[i] >= CNT_WIDTH'(AFULL_LEVEL)) begin
                almost_full = 1'b1;
            end
        end
    end

    // Each FIFO holds its last popped row, so remembering which FIFO
    // popped last is enough to keep fifo_data stable between pops.
    always_comb begin
        sel_d   = sel_q;
        valid_d = |rd_ok_v;
        for (int i = 0; i < SA_NUM; i++) begin
            if (rd_ok_v[i]) begin
                sel_d = SEL_WIDTH'(i);
            end
        end
    end

    always_comb begin
        tile_beats_d = tile_beats_q;
        beat_cnt_d   = beat_cnt_q;
        add_end_d    = 1'b0;
        if (tile_start && tile_beats != '0) begin
            tile_beats_d = tile_beats;
            beat_cnt_d   = '0;
            if (beat) begin
                if (tile_beats == BEAT_WIDTH'(1)) begin
                    add_end_d = 1'b1;
                end else begin
                    beat_cnt_d = BEAT_WIDTH'(1);
                end
            end
        end else if (beat && tile_beats_q != '0) begin
            if (beat_cnt_q + BEAT_WIDTH'(1) == tile_beats_q) begin
                add_end_d  = 1'b1;
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + BEAT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        ovf_err_d   = ovf_err_q | (|ovf_v);
        udf_err_d   = udf_err_q | (|udf_v);
        multi_err_d = multi_err_q | multi_rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q        <= '0;
            valid_q      <= 1'b0;
            tile_beats_q <= '0;
            beat_cnt_q   <= '0;
            add_end_q    <= 1'b0;
            ovf_err_q    <= 1'b0;
            udf_err_q    <= 1'b0;
            multi_err_q  <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            valid_q      <= valid_d;
            tile_beats_q <= tile_beats_d;
            beat_cnt_q   <= beat_cnt_d;
            add_end_q    <= add_end_d;
            ovf_err_q    <= ovf_err_d;
            udf_err_q    <= udf_err_d;
            multi_err_q  <= multi_err_d;
        end
    end

    assign fifo_data        = dout_a[sel_q];
    assign fifo_data_valid  = valid_q;
    assign quantify_add_end = add_end_q;
    assign overflow_err     = ovf_err_q;
    assign underflow_err    = udf_err_q;
    assign multi_rd_err     = multi_err_q;

endmodule

// File: tb/tb_conv_out_fifo_bank.sv
// Scoreboard bench for conv_out_fifo_bank: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_conv_out_fifo_bank;
    import conv_out_pkg::*;

    localparam int W = ROW_WIDTH;
    localparam int N = SA_NUM;

    logic                  clk;
    logic                  reset;
    logic                  tile_start;
    logic [BEAT_WIDTH-1:0] tile_beats;
    logic [N-1:0]          wr_en;
    logic [N*W-1:0]        wr_data;
    logic [N-1:0]          fifo_rds;
    logic [W-1:0]          fifo_data;
    logic                  fifo_data_valid;
    logic [N-1:0]          full;
    logic [N-1:0]          empty;
    logic                  almost_full;
    logic                  quantify_add_end;
    logic                  overflow_err;
    logic                  underflow_err;
    logic                  multi_rd_err;

    conv_out_fifo_bank dut (
        .clk              (clk),
        .reset            (reset),
        .tile_start       (tile_start),
        .tile_beats       (tile_beats),
        .wr_en            (wr_en),
        .wr_data          (wr_data),
        .fifo_rds         (fifo_rds),
        .fifo_data        (fifo_data),
        .fifo_data_valid  (fifo_data_valid),
        .full             (full),
        .empty            (empty),
        .almost_full      (almost_full),
        .quantify_add_end (quantify_add_end),
        .overflow_err     (overflow_err),
        .underflow_err    (underflow_err),
        .multi_rd_err     (multi_rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [W-1:0] mq [N][$];
    int           m_tb;
    int           m_cnt;
    bit           m_ovf, m_udf, m_multi;
    logic [W-1:0] m_last;

    // Scoreboard queues
    logic [W-1:0] exp_data [$];
    int           exp_cyc  [$];
    int           end_cyc  [$];

    int           n_cmp, n_bad, cyc;
    bit           use_pat;
    logic [W-1:0] pat [N];

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     name, cyc, act, req);
        end
    endtask

    function automatic logic [N-1:0] bit_of(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check_state();
        logic [N-1:0] e, f;
        logic         af;
        af = 1'b0;
        for (int i = 0; i < N; i++) begin
            e[i] = (mq[i].size() == 0);
            f[i] = (mq[i].size() == FIFO_DEPTH);
            if (mq[i].size() >= FIFO_DEPTH - 2) af = 1'b1;
        end
        check("empty", W'(empty), W'(e));
        check("full", W'(full), W'(f));
        check("almost_full", W'(almost_full), W'(af));
        check("overflow_err", W'(overflow_err), W'(m_ovf));
        check("underflow_err", W'(underflow_err), W'(m_udf));
        check("multi_rd_err", W'(multi_rd_err), W'(m_multi));
        check("fifo_data_hold", fifo_data, m_last);
    endtask

    // Applies one cycle of stimulus and advances the model to the state
    // the DUT should reach at the coming clock edge.
    task automatic drive(input logic [N-1:0] we, input logic [N-1:0] rd,
                         input logic ts, input logic [15:0] tbv,
                         input logic rst);
        logic [W-1:0] d [N];
        bit           acc [N];
        int           nacc, pidx, idx;
        logic [W-1:0] v;
        @(negedge clk);
        check_state();
        reset      = rst;
        wr_en      = we;
        fifo_rds   = rd;
        tile_start = ts;
        tile_beats = tbv;
        for (int i = 0; i < N; i++) begin
            d[i] = use_pat ? pat[i] : {16{$urandom()}};
            wr_data[i*W +: W] = d[i];
        end
        if (rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_tb = 0; m_cnt = 0;
            m_ovf = 0; m_udf = 0; m_multi = 0;
            m_last = '0;
        end else begin
            pidx = -1;
            idx  = 0;
            if ($countones(rd) > 1) begin
                m_multi = 1;
            end else if (rd != 0) begin
                for (int i = 0; i < N; i++) if (rd[i]) idx = i;
                if (mq[idx].size() > 0) pidx = idx;
                else m_udf = 1;
            end
            nacc = 0;
            for (int i = 0; i < N; i++) begin
                acc[i] = 0;
                if (we[i]) begin
                    if (mq[i].size() < FIFO_DEPTH) begin
                        acc[i] = 1;
                        nacc++;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            if (pidx >= 0) begin
                v = mq[pidx].pop_front();
                m_last = v;
                exp_data.push_back(v);
                exp_cyc.push_back(cyc + 1);
            end
            for (int i = 0; i < N; i++) if (acc[i]) mq[i].push_back(d[i]);
            if (ts && tbv != 0) begin
                m_tb  = int'(tbv);
                m_cnt = 0;
                if (nacc > 0) m_cnt = 1;
            end else if (nacc > 0 && m_tb != 0) begin
                m_cnt++;
            end
            if (m_tb != 0 && m_cnt == m_tb) begin
                m_cnt = 0;
                end_cyc.push_back(cyc + 1);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive('0, '0, 1'b0, 16'd0, 1'b0);
    endtask

    task automatic drain_all();
        for (int i = 0; i < N; i++)
            while (mq[i].size() > 0) drive('0, bit_of(i), 1'b0, 16'd0, 1'b0);
    endtask

    // Monitor: compares every DUT output event against the scoreboard.
    initial begin
        logic [W-1:0] ed;
        int           ec;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (fifo_data_valid) begin
                if (exp_cyc.size() == 0) begin
                    check("unexpected_valid", W'(1), W'(0));
                end else begin
                    ed = exp_data.pop_front();
                    ec = exp_cyc.pop_front();
                    check("pop_cycle", W'(cyc), W'(ec));
                    check("pop_data", fifo_data, ed);
                end
            end else if (exp_cyc.size() > 0 && exp_cyc[0] <= cyc) begin
                check("missing_valid", W'(0), W'(1));
                void'(exp_data.pop_front());
                void'(exp_cyc.pop_front());
            end
            if (quantify_add_end) begin
                if (end_cyc.size() == 0) begin
                    check("unexpected_add_end", W'(1), W'(0));
                end else begin
                    ec = end_cyc.pop_front();
                    check("add_end_cycle", W'(cyc), W'(ec));
                end
            end else if (end_cyc.size() > 0 && end_cyc[0] <= cyc) begin
                check("missing_add_end", W'(0), W'(1));
                void'(end_cyc.pop_front());
            end
        end
    end

    initial begin
        logic [N-1:0] we, rd;
        int           r;
        n_cmp = 0; n_bad = 0; cyc = 0;
        use_pat = 0;
        m_tb = 0; m_cnt = 0; m_ovf = 0; m_udf = 0; m_multi = 0;
        m_last = '0;
        reset = 1'b1; tile_start = 1'b0; tile_beats = '0;
        wr_en = '0; fifo_rds = '0; wr_data = '0;

        drive('0, '0, 1'b0, 16'd0, 1'b1);
        drive('0, '0, 1'b0, 16'd0, 1'b1);
        idle(1);

        // Basic tile: 4 full-width beats, then FIFO 5 drained
        drive('0, '0, 1'b1, 16'd4, 1'b0);
        use_pat = 1;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < N; i++) pat[i] = W'((i << 8) | b);
            drive({N{1'b1}}, '0, 1'b0, 16'd0, 1'b0);
        end
        use_pat = 0;
        for (int k = 0; k < 4; k++) drive('0, bit_of(5), 1'b0, 16'd0, 1'b0);
        drain_all();

        // Fill FIFO 0 past full, then drain it
        for (int k = 0; k < 33; k++) drive(bit_of(0), '0, 1'b0, 16'd0, 1'b0);
        drive(bit_of(0), bit_of(0), 1'b0, 16'd0, 1'b0);
        drain_all();

        // Underflow with hold value, same-cycle write to the empty FIFO
        use_pat = 1;
        for (int i = 0; i < N; i++) pat[i] = W'(8'hAB);
        drive(bit_of(2), '0, 1'b0, 16'd0, 1'b0);
        drive('0, bit_of(2), 1'b0, 16'd0, 1'b0);
        pat[3] = W'(16'h0377);
        drive(bit_of(3), bit_of(3), 1'b0, 16'd0, 1'b0);
        drive('0, bit_of(3), 1'b0, 16'd0, 1'b0);
        use_pat = 0;

        // Multi-hot read rejected
        drive(bit_of(0) | bit_of(1), '0, 1'b0, 16'd0, 1'b0);
        drive('0, 12'h003, 1'b0, 16'd0, 1'b0);
        drain_all();

        // Concurrent push/pop on FIFO 7 across pointer wrap
        for (int k = 0; k < 10; k++) drive(bit_of(7), '0, 1'b0, 16'd0, 1'b0);
        for (int k = 0; k < 50; k++) drive(bit_of(7), bit_of(7), 1'b0, 16'd0, 1'b0);
        drain_all();

        // Reset mid-tile, then a fresh 2-beat tile
        drive('0, '0, 1'b1, 16'd8, 1'b0);
        for (int k = 0; k < 5; k++) drive(12'h0F0, '0, 1'b0, 16'd0, 1'b0);
        drive('0, '0, 1'b0, 16'd0, 1'b1);
        drive(12'h001, '0, 1'b0, 16'd0, 1'b0);
        drive('0, '0, 1'b1, 16'd2, 1'b0);
        drive(12'h001, '0, 1'b0, 16'd0, 1'b0);
        drive(12'h002, '0, 1'b0, 16'd0, 1'b0);
        idle(2);
        drain_all();

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            we = ($urandom_range(0, 2) == 0) ? N'($urandom()) : '0;
            r  = $urandom_range(0, 9);
            if (r < 6)      rd = bit_of($urandom_range(0, N - 1));
            else if (r < 8) rd = '0;
            else            rd = N'($urandom());
            drive(we, rd, ($urandom_range(0, 24) == 0),
                  16'($urandom_range(0, 6)), ($urandom_range(0, 199) == 0));
        end
        drain_all();
        idle(3);

        check("pending_pops", W'(exp_cyc.size()), W'(0));
        check("pending_add_end", W'(end_cyc.size()), W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
